// File: rtl/dual_port_ram_pipelined.sv
// Simple dual-port RAM: byte-strobe writes, write-first per-byte bypass, READ_LATENCY-stage read pipeline.
// Define DPRAM_CLEAR_ON_RESET_EN to add the post-reset clear engine that zeroes the array while busy is high.
module dual_port_ram_pipelined #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    ren,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    busy
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : gBadLatency
      $error("dual_port_ram_pipelined: READ_LATENCY must be in 1..4");
    end
    if (DATA_WIDTH % 8 != 0) begin : gBadWidth
      $error("dual_port_ram_pipelined: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]   memArray [DEPTH];
  logic [DATA_WIDTH-1:0]   readWord;
  logic [DATA_WIDTH-1:0]   pipeData [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipeValid;
  logic                    wenAccepted;
  logic                    renAccepted;
  logic                    clearWen;
  logic [ADDR_WIDTH-1:0]   clearAddr;

`ifdef DPRAM_CLEAR_ON_RESET_EN
  typedef enum logic {
    IDLE,
    CLEAR
  } clearState_t;

  clearState_t           state;
  clearState_t           nextState;
  logic [ADDR_WIDTH-1:0] clearAddrNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      clearAddr <= '0;
    end else begin
      state     <= nextState;
      clearAddr <= clearAddrNext;
    end
  end

  // One zero word per cycle; the last address hands control back to IDLE.
  always_comb begin
    nextState     = state;
    clearAddrNext = clearAddr;
    clearWen      = 1'b0;
    case (state)
      IDLE: begin
        nextState = IDLE;
      end
      CLEAR: begin
        clearWen      = !reset;
        clearAddrNext = clearAddr + 1'b1;
        if (clearAddr == '1) nextState = IDLE;
      end
    endcase
  end

  assign busy = (state == CLEAR);
`else
  assign clearAddr = '0;
  assign clearWen  = 1'b0;
  assign busy      = 1'b0;
`endif

  assign wenAccepted = wen && !busy && !reset;
  assign renAccepted = ren && !busy && !reset;

  always_ff @(posedge clock) begin
    if (clearWen) begin
      memArray[clearAddr] <= '0;
    end else if (wenAccepted) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wstrb[i]) memArray[waddr][8*i +: 8] <= din[8*i +: 8];
      end
    end
  end

  // Same-cycle collision returns the strobed bytes of din and the stored bytes elsewhere.
  always_comb begin
    readWord = memArray[raddr];
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (wenAccepted && (waddr == raddr) && wstrb[i]) readWord[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Data stages only load alongside a valid so dout holds its last result between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipeValid <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipeData[k] <= '0;
    end else begin
      pipeValid[0] <= renAccepted;
      if (renAccepted) pipeData[0] <= readWord;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipeValid[k] <= pipeValid[k-1];
        if (pipeValid[k-1]) pipeData[k] <= pipeData[k-1];
      end
    end
  end

  assign dout       = pipeData[READ_LATENCY-1];
  assign dout_valid = pipeValid[READ_LATENCY-1];

endmodule

// File: tb/tb_dual_port_ram_pipelined.sv
// Self-checking bench for dual_port_ram_pipelined (AW=4, DW=32, latency 2); a cycle-indexed array/queue
// model predicts busy, dout_valid and dout, and each test task compares its own cycle window.
module tb_dual_port_ram_pipelined;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;
  localparam int MAXC  = 4096;
`ifdef DPRAM_CLEAR_ON_RESET_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wen   = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [3:0]    wstrb = '0;
  logic [DW-1:0] din   = '0;
  logic          ren   = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] dout;
  logic          doutValid;
  logic          busy;

  dual_port_ram_pipelined #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wen       (wen),
    .waddr     (waddr),
    .wstrb     (wstrb),
    .din       (din),
    .ren       (ren),
    .raddr     (raddr),
    .dout      (dout),
    .dout_valid(doutValid),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  int            busyLeft = 0;
  int            cyc = 0;
  int            resetDone = 0;
  int            total = 0;
  int            bad = 0;

  bit            expValid [MAXC];
  bit            expKnown [MAXC];
  logic [DW-1:0] expData  [MAXC];
  logic          obsValid [MAXC];
  logic [DW-1:0] obsData  [MAXC];
  logic          obsBusy  [MAXC];

  // One cycle: record outputs seen at this negedge, drive inputs, advance the model.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [3:0] ws,
                               input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ra);
    logic [DW-1:0] word;
    bit            accepted;
    bit            wordKnown;
    if (cyc >= MAXC - 8) begin
      $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 8);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    obsValid[cyc] = doutValid;
    obsData[cyc]  = dout;
    obsBusy[cyc]  = busy;
    wen = w; waddr = wa; wstrb = ws; din = d; ren = r; raddr = ra;
    accepted = (busyLeft == 0);
    if (r && accepted) begin
      word      = model[ra];
      wordKnown = known[ra];
      if (w && wa == ra) begin
        for (int i = 0; i < 4; i++) if (ws[i]) word[8*i +: 8] = d[8*i +: 8];
        if (ws == 4'hF) wordKnown = 1'b1;
      end
      expValid[cyc + LAT] = 1'b1;
      expData[cyc + LAT]  = word;
      expKnown[cyc + LAT] = wordKnown;
    end
    if (w && accepted) begin
      for (int i = 0; i < 4; i++) if (ws[i]) model[wa][8*i +: 8] = d[8*i +: 8];
      if (ws == 4'hF) known[wa] = 1'b1;
    end
    if (busyLeft > 0) busyLeft--;
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 4'h0, '0, 1'b0, '0);
  endtask

  task automatic resetDut(input int n);
    int first;
    first = cyc;
    reset = 1'b1; wen = 1'b0; ren = 1'b0;
    for (int i = 0; i < n; i++) begin
      obsValid[cyc] = doutValid;
      obsData[cyc]  = dout;
      obsBusy[cyc]  = busy;
      @(negedge clock);
      cyc++;
    end
    for (int c = first + 1; c <= first + n + LAT; c++) expValid[c] = 1'b0;
    reset     = 1'b0;
    busyLeft  = CLEAR_EN ? DEPTH : 0;
    resetDone = cyc;
    for (int a = 0; a < DEPTH; a++) begin
      model[a] = '0;
      known[a] = CLEAR_EN;
    end
  endtask

  task automatic zeroFillIfNoClear();
    if (!CLEAR_EN) for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, AW'(a), 4'hF, '0, 1'b0, '0);
  endtask

  task automatic test_reset();
    resetDut(3);
    idle(1);
    total++;
    if (obsValid[resetDone] !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_valid got=%b want=0", obsValid[resetDone]);
    end
    total++;
    if (obsData[resetDone] !== '0) begin
      bad++; $display("[TB] FAIL reset_dout got=%h want=0", obsData[resetDone]);
    end
    total++;
    if (obsBusy[resetDone] !== CLEAR_EN) begin
      bad++; $display("[TB] FAIL reset_busy got=%b want=%b", obsBusy[resetDone], CLEAR_EN);
    end
  endtask

  task automatic test_clear();
    int busyCount;
    int start;
    start = resetDone;
    while (cyc < start + DEPTH + 4)
      applyStimulus(1'($urandom), AW'($urandom), 4'($urandom), $urandom, 1'($urandom), AW'($urandom));
    busyCount = 0;
    for (int c = start; c < start + DEPTH + 4; c++) if (obsBusy[c] === 1'b1) busyCount++;
    total++;
    if (busyCount != (CLEAR_EN ? DEPTH : 0)) begin
      bad++; $display("[TB] FAIL clear_busy_cycles got=%0d want=%0d", busyCount, CLEAR_EN ? DEPTH : 0);
    end
    total++;
    if (obsBusy[start + DEPTH] !== 1'b0) begin
      bad++; $display("[TB] FAIL clear_busy_fall got=%b want=0", obsBusy[start + DEPTH]);
    end
    zeroFillIfNoClear();
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, AW'(a));
    idle(LAT + 1);
    for (int c = start + 1; c < cyc; c++) begin
      total++;
      if (obsValid[c] !== expValid[c]) begin
        bad++; $display("[TB] FAIL clear_valid cyc=%0d got=%b want=%b", c, obsValid[c], expValid[c]);
      end
      if (expValid[c] && expKnown[c]) begin
        total++;
        if (obsData[c] !== expData[c]) begin
          bad++; $display("[TB] FAIL clear_data cyc=%0d got=%h want=%h", c, obsData[c], expData[c]);
        end
      end
    end
  endtask

  task automatic test_basic();
    int t;
    applyStimulus(1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b0, '0);
    t = cyc;
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd3);
    idle(LAT + 2);
    for (int c = t + 1; c <= t + LAT + 1; c++) begin
      total++;
      if (obsValid[c] !== (c == t + LAT)) begin
        bad++; $display("[TB] FAIL basic_latency cyc=%0d got=%b want=%b", c, obsValid[c], c == t + LAT);
      end
    end
    total++;
    if (obsData[t + LAT] !== expData[t + LAT]) begin
      bad++; $display("[TB] FAIL basic_data got=%h want=%h", obsData[t + LAT], expData[t + LAT]);
    end
  endtask

  task automatic test_byte_strobe();
    int t;
    applyStimulus(1'b1, 4'd5, 4'hF, 32'h11223344, 1'b0, '0);
    applyStimulus(1'b1, 4'd5, 4'h5, 32'hAABBCCDD, 1'b0, '0);
    applyStimulus(1'b1, 4'd5, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
    t = cyc;
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd5);
    idle(LAT + 1);
    total++;
    if (obsValid[t + LAT] !== 1'b1 || obsData[t + LAT] !== expData[t + LAT]) begin
      bad++; $display("[TB] FAIL byte_strobe got=%b/%h want=1/%h", obsValid[t + LAT], obsData[t + LAT], expData[t + LAT]);
    end
  endtask

  task automatic test_bypass();
    int t;
    applyStimulus(1'b1, 4'd7, 4'hF, 32'h0, 1'b0, '0);
    t = cyc;
    applyStimulus(1'b1, 4'd7, 4'h3, 32'hCAFEF00D, 1'b1, 4'd7);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd7);
    idle(LAT + 1);
    for (int c = t + LAT; c <= t + LAT + 1; c++) begin
      total++;
      if (obsValid[c] !== 1'b1 || obsData[c] !== expData[c]) begin
        bad++; $display("[TB] FAIL bypass cyc=%0d got=%b/%h want=1/%h", c, obsValid[c], obsData[c], expData[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t;
    applyStimulus(1'b1, 4'd2, 4'hF, 32'h5, 1'b0, '0);
    t = cyc;
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd2);
    applyStimulus(1'b1, 4'd2, 4'hF, 32'h9, 1'b1, 4'd1);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd2);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd3);
    idle(LAT + 1);
    for (int c = t + LAT; c < t + LAT + 4; c++) begin
      total++;
      if (obsValid[c] !== 1'b1) begin
        bad++; $display("[TB] FAIL back_to_back_valid cyc=%0d got=%b want=1", c, obsValid[c]);
      end
      if (expKnown[c]) begin
        total++;
        if (obsData[c] !== expData[c]) begin
          bad++; $display("[TB] FAIL back_to_back_data cyc=%0d got=%h want=%h", c, obsData[c], expData[c]);
        end
      end
    end
    total++;
    if (obsValid[t + LAT + 4] !== 1'b0) begin
      bad++; $display("[TB] FAIL back_to_back_tail got=%b want=0", obsValid[t + LAT + 4]);
    end
  endtask

  task automatic test_random();
    int start;
    start = cyc;
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), AW'($urandom_range(0, 3)), 4'($urandom), $urandom,
                    1'($urandom), AW'($urandom_range(0, 3)));
    idle(LAT + 1);
    for (int c = start; c < cyc; c++) begin
      total++;
      if (obsValid[c] !== expValid[c]) begin
        bad++; $display("[TB] FAIL random_valid cyc=%0d got=%b want=%b", c, obsValid[c], expValid[c]);
      end
      if (expValid[c] && expKnown[c]) begin
        total++;
        if (obsData[c] !== expData[c]) begin
          bad++; $display("[TB] FAIL random_data cyc=%0d got=%h want=%h", c, obsData[c], expData[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int r;
    int start;
    int busyCount;
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd3);
    applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, 4'd5);
    r = cyc;
    resetDut(1);
    idle(5);
    for (int c = r + 1; c < r + 6; c++) begin
      total++;
      if (obsValid[c] !== 1'b0 || obsData[c] !== '0) begin
        bad++; $display("[TB] FAIL flush cyc=%0d got=%b/%h want=0/0", c, obsValid[c], obsData[c]);
      end
    end
    resetDut(2);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, AW'(i));
    resetDut(1);
    start = resetDone;
    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b1, AW'(i), 4'hF, 32'hA5A5A5A5, 1'b1, AW'(i));
    busyCount = 0;
    for (int c = start; c < start + DEPTH + 4; c++) if (obsBusy[c] === 1'b1) busyCount++;
    total++;
    if (busyCount != (CLEAR_EN ? DEPTH : 0)) begin
      bad++; $display("[TB] FAIL restart_busy_cycles got=%0d want=%0d", busyCount, CLEAR_EN ? DEPTH : 0);
    end
    zeroFillIfNoClear();
    for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, '0, 4'h0, '0, 1'b1, AW'(a));
    idle(LAT + 1);
    for (int c = start + 1; c < cyc; c++) begin
      total++;
      if (obsValid[c] !== expValid[c]) begin
        bad++; $display("[TB] FAIL restart_valid cyc=%0d got=%b want=%b", c, obsValid[c], expValid[c]);
      end
      if (expValid[c] && expKnown[c]) begin
        total++;
        if (obsData[c] !== expData[c]) begin
          bad++; $display("[TB] FAIL restart_data cyc=%0d got=%h want=%h", c, obsData[c], expData[c]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clock);
    $display("[TB] start, clear engine=%0d", CLEAR_EN);
    test_reset();
    test_clear();
    test_basic();
    test_byte_strobe();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
